reg_rename_file: RTL and testbench



---
 rtl/reg_rename_file_pkg.sv | 25 ++
 rtl/reg_rename_file_read_port.sv | 64 ++++++
 rtl/reg_rename_file.sv | 114 +++++++++++
 tb/tb_reg_rename_file.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/reg_rename_file_pkg.sv
// ---------------------------------------------------------------------------
// reg_rename_file_pkg
// Shared defaults and types for the rename register file.
//   - *_DEF localparams: default widths/counts used as module parameter
//     defaults, so every file agrees on one configuration.
//   - read_src_e: which source feeds a read port. The encoding lists the
//     sources in priority order.
// ---------------------------------------------------------------------------
package reg_rename_file_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREG_DEF  = 32;
    localparam int REG_W_DEF = 5;
    localparam int ROB_W_DEF = 4;
    localparam int NRD_DEF   = 2;

    typedef enum logic [2:0] {
        SRC_ZERO   = 3'd0,  // x0: constant zero
        SRC_REG    = 3'd1,  // not renamed: architectural value
        SRC_BYPASS = 3'd2,  // matching commit in this cycle
        SRC_ROB    = 3'd3,  // ROB already holds the finished result
        SRC_TAG    = 3'd4   // still pending: forward the tag instead
    } read_src_e;

endpackage

// File: rtl/reg_rename_file_read_port.sv
// ---------------------------------------------------------------------------
// rename_read_port
// Priority mux for one source operand read port. It is purely combinational.
// Ports:
//   idx      : source register index
//   reg_val  : architectural value of idx (pre-edge)
//   busy/tag : rename state of idx (pre-edge)
//   cm_*     : commit in flight this cycle, used for the same-cycle bypass
//   q_rdy/q_val : ROB lookup result for tag
//   val/rdy  : operand value (or zero-extended tag) and its ready flag
// ---------------------------------------------------------------------------
module rename_read_port
    import reg_rename_file_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int REG_W = REG_W_DEF,
    parameter int ROB_W = ROB_W_DEF
) (
    input  logic [REG_W-1:0] idx,
    input  logic [XLEN-1:0]  reg_val,
    input  logic             busy,
    input  logic [ROB_W-1:0] tag,
    input  logic             cm_sgn,
    input  logic [REG_W-1:0] cm_dest,
    input  logic [ROB_W-1:0] cm_tag,
    input  logic [XLEN-1:0]  cm_val,
    input  logic             q_rdy,
    input  logic [XLEN-1:0]  q_val,
    output logic [XLEN-1:0]  val,
    output logic             rdy
);

    read_src_e src;

    // Select the source first. The first match wins.
    always_comb begin
        src = SRC_TAG;
        if (idx == '0) begin
            src = SRC_ZERO;
        end else if (!busy) begin
            src = SRC_REG;
        end else if (cm_sgn && (cm_dest == idx) && (cm_tag == tag)) begin
            src = SRC_BYPASS;
        end else if (q_rdy) begin
            src = SRC_ROB;
        end
    end

    always_comb begin
        val = '0;
        rdy = 1'b1;
        unique case (src)
            SRC_ZERO:   val = '0;
            SRC_REG:    val = reg_val;
            SRC_BYPASS: val = cm_val;
            SRC_ROB:    val = q_val;
            default: begin
                val = XLEN'(tag);
                rdy = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/reg_rename_file.sv
// ---------------------------------------------------------------------------
// reg_rename_file
// Architectural register file with per-register rename state (busy + ROB tag).
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   rdy                 : global enable; state is frozen while low
//   rd_idx              : NRD packed source indices (port 0 in the LSBs)
//   rd_val/rd_rdy       : operand value (or the pending tag) and ready flag
//   rob_qtag            : tag of each source, sent to the ROB for lookup
//   rob_qrdy/rob_qval   : ROB lookup result per port
//   is_sgn/is_rd/is_tag : rename of a destination at issue
//   cm_sgn/cm_dest/cm_val/cm_tag : ROB commit
//   flush               : mispredict; drops every outstanding rename
// Reads see only pre-edge state, so a same-cycle issue to a source register
// does not affect that read.
// ---------------------------------------------------------------------------
module reg_rename_file
    import reg_rename_file_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREG  = NREG_DEF,
    parameter int REG_W = REG_W_DEF,
    parameter int ROB_W = ROB_W_DEF,
    parameter int NRD   = NRD_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic [NRD*REG_W-1:0]  rd_idx,
    output logic [NRD*XLEN-1:0]   rd_val,
    output logic [NRD-1:0]        rd_rdy,
    output logic [NRD*ROB_W-1:0]  rob_qtag,
    input  logic [NRD-1:0]        rob_qrdy,
    input  logic [NRD*XLEN-1:0]   rob_qval,
    input  logic                  is_sgn,
    input  logic [REG_W-1:0]      is_rd,
    input  logic [ROB_W-1:0]      is_tag,
    input  logic                  cm_sgn,
    input  logic [REG_W-1:0]      cm_dest,
    input  logic [XLEN-1:0]       cm_val,
    input  logic [ROB_W-1:0]      cm_tag,
    input  logic                  flush
);

    logic [XLEN-1:0]  reg_q  [NREG];
    logic [XLEN-1:0]  reg_d  [NREG];
    logic [ROB_W-1:0] tag_q  [NREG];
    logic [ROB_W-1:0] tag_d  [NREG];
    logic [NREG-1:0]  busy_q;
    logic [NREG-1:0]  busy_d;

    // The commit is applied first, so an issue to the same register in the
    // same cycle overwrites busy/tag. A flush then clears every busy bit.
    // The commit value is still written, and a same-cycle issue is dropped.
    always_comb begin
        reg_d  = reg_q;
        tag_d  = tag_q;
        busy_d = busy_q;
        if (cm_sgn && (cm_dest != '0)) begin
            reg_d[cm_dest] = cm_val;
            // Only the rename that produced this value may be retired. A
            // younger rename keeps the register busy.
            if (busy_q[cm_dest] && (tag_q[cm_dest] == cm_tag)) begin
                busy_d[cm_dest] = 1'b0;
            end
        end
        if (flush) begin
            busy_d = '0;
        end else if (is_sgn && (is_rd != '0)) begin
            busy_d[is_rd] = 1'b1;
            tag_d[is_rd]  = is_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
            for (int i = 0; i < NREG; i++) begin
                reg_q[i] <= '0;
                tag_q[i] <= '0;
            end
        end else if (rdy) begin
            busy_q <= busy_d;
            reg_q  <= reg_d;
            tag_q  <= tag_d;
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [REG_W-1:0] idx;
        assign idx = rd_idx[p*REG_W +: REG_W];
        assign rob_qtag[p*ROB_W +: ROB_W] = tag_q[idx];

        rename_read_port #(
            .XLEN  (XLEN),
            .REG_W (REG_W),
            .ROB_W (ROB_W)
        ) u_port (
            .idx     (idx),
            .reg_val (reg_q[idx]),
            .busy    (busy_q[idx]),
            .tag     (tag_q[idx]),
            .cm_sgn  (cm_sgn),
            .cm_dest (cm_dest),
            .cm_tag  (cm_tag),
            .cm_val  (cm_val),
            .q_rdy   (rob_qrdy[p]),
            .q_val   (rob_qval[p*XLEN +: XLEN]),
            .val     (rd_val[p*XLEN +: XLEN]),
            .rdy     (rd_rdy[p])
        );
    end

endmodule

// File: tb/tb_reg_rename_file.sv
module tb_reg_rename_file;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic [9:0]  rd_idx;
    logic [63:0] rd_val;
    logic [1:0]  rd_rdy;
    logic [7:0]  rob_qtag;
    logic [1:0]  rob_qrdy;
    logic [63:0] rob_qval;
    logic        is_sgn;
    logic [4:0]  is_rd;
    logic [3:0]  is_tag;
    logic        cm_sgn;
    logic [4:0]  cm_dest;
    logic [31:0] cm_val;
    logic [3:0]  cm_tag;
    logic        flush;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    reg_rename_file dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .rd_idx(rd_idx), .rd_val(rd_val), .rd_rdy(rd_rdy),
        .rob_qtag(rob_qtag), .rob_qrdy(rob_qrdy), .rob_qval(rob_qval),
        .is_sgn(is_sgn), .is_rd(is_rd), .is_tag(is_tag),
        .cm_sgn(cm_sgn), .cm_dest(cm_dest), .cm_val(cm_val), .cm_tag(cm_tag),
        .flush(flush)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock edge, then let the combinational outputs settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] p0, input logic [4:0] p1);
        rd_idx = {p1, p0};
        #1;
    endtask

    task automatic idle();
        is_sgn = 0; cm_sgn = 0; flush = 0; rob_qrdy = 0;
    endtask

    initial begin
        rst = 1; rdy = 1; rd_idx = '0; rob_qrdy = 0; rob_qval = '0;
        is_sgn = 0; is_rd = 0; is_tag = 0;
        cm_sgn = 0; cm_dest = 0; cm_val = 0; cm_tag = 0; flush = 0;
        // Rename x9 while reset is held: reset must win.
        is_sgn = 1; is_rd = 9; is_tag = 6;
        tick(); tick();
        rst = 0; idle();

        // Reset state
        rd(5, 0);
        check("rst_rdy", 64'(rd_rdy), 64'h3);
        check("rst_val", rd_val, 64'h0);
        check("rst_qtag", 64'(rob_qtag), 64'h0);
        rd(9, 9);
        check("rst_mid_rename_rdy", 64'(rd_rdy), 64'h3);

        // Issue x3 tag 4, then read pending and ROB-forwarded
        is_sgn = 1; is_rd = 3; is_tag = 4;
        tick(); idle();
        rob_qrdy = 2'b10; rob_qval = {32'hDEAD, 32'h0};
        rd(3, 3);
        check("pend_rdy0", 64'(rd_rdy[0]), 64'h0);
        check("pend_val0", 64'(rd_val[31:0]), 64'h4);
        check("pend_qtag0", 64'(rob_qtag[3:0]), 64'h4);
        check("rob_rdy1", 64'(rd_rdy[1]), 64'h1);
        check("rob_val1", 64'(rd_val[63:32]), 64'hDEAD);
        rob_qrdy = 0;

        // Commit bypass, then committed value
        cm_sgn = 1; cm_dest = 3; cm_tag = 4; cm_val = 32'h55;
        #1;
        check("byp_rdy", 64'(rd_rdy[0]), 64'h1);
        check("byp_val", 64'(rd_val[31:0]), 64'h55);
        tick(); idle();
        #1;
        check("cm_rdy", 64'(rd_rdy[0]), 64'h1);
        check("cm_val", 64'(rd_val[31:0]), 64'h55);

        // Stale commit keeps the younger rename
        is_sgn = 1; is_rd = 3; is_tag = 4; tick();
        is_tag = 7; tick(); idle();
        cm_sgn = 1; cm_dest = 3; cm_tag = 4; cm_val = 32'h11;
        tick(); idle();
        rd(3, 0);
        check("young_rdy", 64'(rd_rdy[0]), 64'h0);
        check("young_tag", 64'(rd_val[31:0]), 64'h7);

        // Issue and commit to x2 in the same cycle: issue wins
        is_sgn = 1; is_rd = 2; is_tag = 9;
        cm_sgn = 1; cm_dest = 2; cm_tag = 0; cm_val = 32'h33;
        tick(); idle();
        rd(0, 2);
        check("iscm_rdy", 64'(rd_rdy[1]), 64'h0);
        check("iscm_qtag", 64'(rob_qtag[7:4]), 64'h9);

        // Flush with simultaneous issue x4 and commit x1
        is_sgn = 1; is_rd = 1; is_tag = 1;
        tick(); idle();
        flush = 1; is_sgn = 1; is_rd = 4; is_tag = 5;
        cm_sgn = 1; cm_dest = 1; cm_tag = 0; cm_val = 32'h77;
        tick(); idle();
        rd(1, 4);
        check("fl_rdy14", 64'(rd_rdy), 64'h3);
        check("fl_val1", 64'(rd_val[31:0]), 64'h77);
        check("fl_val4", 64'(rd_val[63:32]), 64'h0);
        rd(2, 3);
        check("fl_rdy23", 64'(rd_rdy), 64'h3);
        check("fl_val2", 64'(rd_val[31:0]), 64'h33);
        check("fl_val3", 64'(rd_val[63:32]), 64'h11);

        // Frozen while rdy is low
        rdy = 0; is_sgn = 1; is_rd = 6; is_tag = 3;
        tick(); idle(); rdy = 1;
        rd(6, 0);
        check("frz_rdy", 64'(rd_rdy[0]), 64'h1);
        check("frz_qtag", 64'(rob_qtag[3:0]), 64'h0);

        // x0 is never renamed
        is_sgn = 1; is_rd = 0; is_tag = 2;
        tick(); idle();
        rd(0, 0);
        check("x0_rdy", 64'(rd_rdy), 64'h3);
        check("x0_val", rd_val, 64'h0);
        check("x0_qtag", 64'(rob_qtag), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
